// File: rtl/pc_sequencer_pkg.sv
// Shared constants and FSM encoding for the fetch PC sequencer.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC    = 32'h0000_4180;
    localparam logic [31:0] IMEM_BYTES = 32'h0000_3000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/redirect inputs and fetch-side outputs of the PC sequencer.
interface pc_sequencer_if;

    logic        stall;
    logic        redir_d;
    logic [31:0] redir_pc;
    logic        ctl_d;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        flush_if;
    logic        bd_if;
    logic        adel_if;

    modport master (
        output stall, redir_d, redir_pc, ctl_d,
        output exc_req, eret_req, epc,
        input  pc, pc4, flush_if, bd_if, adel_if
    );

    modport slave (
        input  stall, redir_d, redir_pc, ctl_d,
        input  exc_req, eret_req, epc,
        output pc, pc4, flush_if, bd_if, adel_if
    );

endinterface

// File: rtl/pc_addr_check.sv
// Fetch address check: misaligned or outside [BASE, BASE+SIZE).
module pc_addr_check #(
    parameter logic [31:0] BASE = 32'h0000_3000,
    parameter logic [31:0] SIZE = 32'h0000_3000
) (
    input  logic [31:0] addr,
    output logic        adel
);

    localparam logic [31:0] LIMIT = BASE + SIZE;

    assign adel = (addr[1:0] != 2'b00)
                | (addr < BASE)
                | (addr >= LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with exception/eret/stall/redirect next-PC priority,
// IF flush FSM and branch-delay-slot tracking.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    logic [31:0] pc_q, pc_d;
    state_e      state_q, state_d;
    logic        bd_q, bd_d;
    logic        flush;

    always_comb begin
        pc_d    = pc_q + 32'd4;
        state_d = RUN;
        bd_d    = bd_q;
        flush   = (state_q == FLUSH);
        if (bus.exc_req) begin
            pc_d    = EXC_VEC;
            state_d = FLUSH;
            flush   = 1'b1;
            bd_d    = 1'b0;
        end else if (bus.eret_req) begin
            pc_d    = bus.epc;
            state_d = FLUSH;
            flush   = 1'b1;
            bd_d    = 1'b0;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (state_q == RUN) begin
            bd_d = bus.ctl_d;
            if (bus.redir_d) begin
                pc_d = bus.redir_pc;
            end
        end else begin
            // D slot is being killed, so neither its redirect nor its BD bit count
            bd_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            bd_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            bd_q    <= bd_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc4      = pc_q + 32'd4;
    assign bus.flush_if = flush;
    assign bus.bd_if    = bd_q & ~flush;

    pc_addr_check #(
        .BASE (RESET_PC),
        .SIZE (IMEM_BYTES)
    ) u_addr_check (
        .addr (pc_q),
        .adel (bus.adel_if)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expected PCs queued per step, popped after each edge.
module tb_pc_sequencer;

    logic clk;
    logic reset;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag,
                        input logic [31:0] pc,
                        input logic adel);
        exp_t e;
        e.tag  = tag;
        e.pc   = pc;
        e.adel = adel;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL sb_underflow: observed empty queue expected entry");
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_pc"}, bus.pc, e.pc);
            chk({e.tag, "_pc4"}, bus.pc4, e.pc + 32'd4);
            chk({e.tag, "_adel"}, {31'd0, bus.adel_if}, {31'd0, e.adel});
        end
    endtask

    task automatic chk_fb(input string tag, input logic fl, input logic bd);
        chk({tag, "_flush"}, {31'd0, bus.flush_if}, {31'd0, fl});
        chk({tag, "_bd"}, {31'd0, bus.bd_if}, {31'd0, bd});
    endtask

    initial begin
        reset        = 1'b1;
        bus.stall    = 1'b0;
        bus.redir_d  = 1'b0;
        bus.redir_pc = 32'h0;
        bus.ctl_d    = 1'b0;
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b0;
        bus.epc      = 32'h0;

        // reset state
        #12;
        chk("rst_pc", bus.pc, 32'h3000);
        chk("rst_adel", {31'd0, bus.adel_if}, 32'd0);
        chk_fb("rst", 1'b0, 1'b0);
        reset = 1'b0;

        // sequential fetch
        push("seq1", 32'h3004, 1'b0); tick();
        push("seq2", 32'h3008, 1'b0); tick();
        push("seq3", 32'h300C, 1'b0); tick();
        chk_fb("seq", 1'b0, 1'b0);
        push("seq4", 32'h3010, 1'b0); tick();

        // branch with delay slot
        bus.ctl_d = 1'b1; bus.redir_d = 1'b1; bus.redir_pc = 32'h3100;
        push("br", 32'h3100, 1'b0); tick();
        bus.ctl_d = 1'b0; bus.redir_d = 1'b0;
        chk_fb("br_bd", 1'b0, 1'b1);
        push("br_next", 32'h3104, 1'b0); tick();
        chk_fb("br_bd_clr", 1'b0, 1'b0);

        // jump to 3020 from a branch so bd is set while stalled
        bus.ctl_d = 1'b1; bus.redir_d = 1'b1; bus.redir_pc = 32'h3020;
        push("jmp", 32'h3020, 1'b0); tick();
        bus.ctl_d = 1'b0; bus.stall = 1'b1; bus.redir_pc = 32'h3040;
        for (int i = 0; i < 3; i++) begin
            push("stall", 32'h3020, 1'b0); tick();
            chk_fb("stall", 1'b0, 1'b1);
        end
        bus.stall = 1'b0;
        push("unstall", 32'h3040, 1'b0); tick();
        bus.redir_d = 1'b0;
        chk_fb("unstall", 1'b0, 1'b0);

        // exception overrides stall
        bus.exc_req = 1'b1; bus.stall = 1'b1; bus.ctl_d = 1'b1;
        #1;
        chk_fb("exc_req_cyc", 1'b1, 1'b0);
        push("exc", 32'h4180, 1'b0); tick();
        bus.exc_req = 1'b0; bus.stall = 1'b0; bus.ctl_d = 1'b0;
        bus.redir_d = 1'b1; bus.redir_pc = 32'h3200;
        #1;
        chk_fb("exc_flush", 1'b1, 1'b0);
        push("exc_noredir", 32'h4184, 1'b0); tick();
        bus.redir_d = 1'b0;
        chk_fb("exc_done", 1'b0, 1'b0);

        // eret
        bus.eret_req = 1'b1; bus.epc = 32'h3044;
        #1;
        chk_fb("eret_req_cyc", 1'b1, 1'b0);
        push("eret", 32'h3044, 1'b0); tick();
        bus.eret_req = 1'b0;
        chk_fb("eret_flush", 1'b1, 1'b0);
        push("eret_next", 32'h3048, 1'b0); tick();
        chk_fb("eret_done", 1'b0, 1'b0);

        // exc + eret together, then back-to-back exception in FLUSH
        bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h3300;
        push("exc_eret", 32'h4180, 1'b0); tick();
        bus.eret_req = 1'b0;
        push("exc_b2b", 32'h4180, 1'b0); tick();
        bus.exc_req = 1'b0;
        chk_fb("b2b_flush", 1'b1, 1'b0);
        push("b2b_next", 32'h4184, 1'b0); tick();

        // address error window and alignment
        bus.redir_d = 1'b1; bus.redir_pc = 32'h3101;
        push("adel_mis", 32'h3101, 1'b1); tick();
        bus.redir_pc = 32'h6000;
        push("adel_hi", 32'h6000, 1'b1); tick();
        bus.redir_pc = 32'h5FFC;
        push("adel_top", 32'h5FFC, 1'b0); tick();
        bus.redir_pc = 32'h2FFC;
        push("adel_lo", 32'h2FFC, 1'b1); tick();
        bus.redir_d = 1'b0;

        // async reset in the middle of FLUSH
        bus.exc_req = 1'b1;
        push("pre_rst", 32'h4180, 1'b0); tick();
        bus.exc_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pc", bus.pc, 32'h3000);
        chk_fb("async_rst", 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        push("post_rst", 32'h3004, 1'b0); tick();

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
